// File: rtl/pe_array_2d.sv
// Output-stationary ROWS x COLS MAC array. Each cell accumulates act[c]*wet[r] over K beats,
// then applies rounding shift, optional ReLU and saturation, and presents the tile on valid/ready.
module pe_array_2d #(
  parameter int ROWS    = 4,
  parameter int COLS    = 8,
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8,
  parameter int BW_ACCU = 32,
  parameter int BW_OUT  = 8,
  parameter int K_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COLS*BW_ACT-1:0]        act_in,
  input  logic [ROWS*BW_WET-1:0]        wet_in,
  input  logic [K_W-1:0]                cfg_k_len,
  input  logic [5:0]                    cfg_shift,
  input  logic                          cfg_round,
  input  logic                          cfg_relu,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROWS*COLS*BW_OUT-1:0]   out_data,
  output logic                          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int NC = ROWS * COLS;
  localparam logic signed [BW_ACCU:0] VMAX = (BW_ACCU+1)'((1 << (BW_OUT-1)) - 1);
  localparam logic signed [BW_ACCU:0] VMIN = ~VMAX;

  logic [1:0]               state_q, state_d;
  logic [K_W-1:0]           cnt_q, cnt_d, klen_q, klen_d;
  logic [5:0]               shift_q, shift_d;
  logic                     round_q, round_d, relu_q, relu_d;
  logic [BW_ACCU-1:0]       acc_q [NC];
  logic [BW_ACCU-1:0]       acc_d [NC];
  logic [BW_ACCU-1:0]       prod  [NC];
  logic [NC*BW_OUT-1:0]     out_q, out_d, post_w;
  logic                     beat;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACC);
  assign beat      = in_valid && in_ready;
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_q;

  // Rounding headroom: the sum is formed one bit wider than the accumulator.
  function automatic logic [BW_OUT-1:0] post_fn(input logic [BW_ACCU-1:0] a,
                                                input logic [5:0] sh,
                                                input logic rnd,
                                                input logic relu);
    int s;
    logic signed [BW_ACCU:0] v;
    s = int'(sh);
    if (s > BW_ACCU-1) s = BW_ACCU-1;
    v = $signed({a[BW_ACCU-1], a});
    if (rnd && s > 0) v = v + ((BW_ACCU+1)'(1) << (s-1));
    v = v >>> s;
    if (relu && v[BW_ACCU]) v = '0;
    if (v > VMAX) v = VMAX;
    if (v < VMIN) v = VMIN;
    return v[BW_OUT-1:0];
  endfunction

  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        prod[r*COLS+c] = BW_ACCU'($signed(act_in[c*BW_ACT +: BW_ACT]) *
                                 $signed(wet_in[r*BW_WET +: BW_WET]));
      end
    end
  end

  always_comb begin
    post_w = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      post_w[i*BW_OUT +: BW_OUT] = post_fn(acc_q[i], shift_q, round_q, relu_q);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    shift_d = shift_q;
    round_d = round_q;
    relu_d  = relu_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          klen_d  = (cfg_k_len == '0) ? K_W'(1) : cfg_k_len;
          shift_d = cfg_shift;
          round_d = cfg_round;
          relu_d  = cfg_relu;
          acc_d   = prod;
          cnt_d   = K_W'(1);
          state_d = (cfg_k_len <= K_W'(1)) ? S_POST : S_ACC;
        end
      end
      S_ACC: begin
        if (beat) begin
          for (int unsigned i = 0; i < NC; i++) acc_d[i] = acc_q[i] + prod[i];
          cnt_d = cnt_q + K_W'(1);
          if (cnt_q + K_W'(1) == klen_q) state_d = S_POST;
        end
      end
      S_POST: begin
        out_d   = post_w;
        state_d = S_OUT;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      shift_q <= '0;
      round_q <= 1'b0;
      relu_q  <= 1'b0;
      out_q   <= '0;
      for (int unsigned i = 0; i < NC; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      shift_q <= shift_d;
      round_q <= round_d;
      relu_q  <= relu_d;
      out_q   <= out_d;
      for (int unsigned i = 0; i < NC; i++) acc_q[i] <= acc_d[i];
    end
  end

endmodule

// File: tb/tb_pe_array_2d.sv
// Scoreboard bench for pe_array_2d: a driver pushes model-computed tiles, a monitor pops on
// each output handshake; directed cases cover latency, saturation, rounding, ReLU, backpressure, abort.
module tb_pe_array_2d;
  localparam int ROWS = 2, COLS = 2, BW_ACT = 8, BW_WET = 8, BW_ACCU = 32, BW_OUT = 8, K_W = 16;
  localparam int NC = ROWS * COLS;
  localparam int NB = NC * BW_OUT;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [COLS*BW_ACT-1:0] act_in = '0;
  logic [ROWS*BW_WET-1:0] wet_in = '0;
  logic [K_W-1:0]         cfg_k_len = '0;
  logic [5:0]             cfg_shift = '0;
  logic                   cfg_round = 1'b0;
  logic                   cfg_relu = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [NB-1:0]          out_data;
  logic                   busy;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] mon_e;
  logic [NB-1:0] snap;
  int            beat_act[64][COLS];
  int            beat_wet[64][ROWS];
  bit            rand_ready_en = 1'b0;
  bit            ok;

  always #5 clk = ~clk;

  pe_array_2d #(
    .ROWS(ROWS), .COLS(COLS), .BW_ACT(BW_ACT), .BW_WET(BW_WET),
    .BW_ACCU(BW_ACCU), .BW_OUT(BW_OUT), .K_W(K_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .act_in(act_in), .wet_in(wet_in), .cfg_k_len(cfg_k_len), .cfg_shift(cfg_shift),
    .cfg_round(cfg_round), .cfg_relu(cfg_relu), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tile got=%h expected=none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e) begin
          n_fail++;
          $display("FAIL tile got=%h expected=%h", out_data, mon_e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  function automatic logic [BW_OUT-1:0] model_cell(input int acc, input int sh, input bit rnd,
                                                   input bit relu);
    int s;
    longint v;
    longint hi, lo;
    hi = (longint'(1) << (BW_OUT-1)) - 1;
    lo = -(longint'(1) << (BW_OUT-1));
    s = (sh > BW_ACCU-1) ? BW_ACCU-1 : sh;
    v = acc;
    if (rnd && s > 0) v = v + (longint'(1) << (s-1));
    v = v >>> s;
    if (relu && v < 0) v = 0;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return BW_OUT'(v);
  endfunction

  task automatic wait_cycles_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        got = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy && !out_valid) return;
      @(posedge clk); #1;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic junk_inputs();
    act_in    = COLS*BW_ACT'($urandom);
    wet_in    = ROWS*BW_WET'($urandom);
    cfg_k_len = K_W'($urandom);
    cfg_shift = 6'($urandom);
    cfg_round = 1'($urandom);
    cfg_relu  = 1'($urandom);
  endtask

  // k is the configured depth; k==0 behaves as a single beat.
  task automatic send_tile(input int k, input int sh, input bit rnd, input bit relu, input bit gaps);
    int nb;
    int acc[ROWS][COLS];
    logic [NB-1:0] e;
    nb = (k == 0) ? 1 : k;
    e = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        acc[r][c] = 0;
        for (int b = 0; b < nb; b++) acc[r][c] += beat_act[b][c] * beat_wet[b][r];
        e[(r*COLS+c)*BW_OUT +: BW_OUT] = model_cell(acc[r][c], sh, rnd, relu);
      end
    exp_q.push_back(e);
    for (int b = 0; b < nb; b++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        junk_inputs();
        @(posedge clk); #1;
      end
      junk_inputs();
      in_valid = 1'b1;
      for (int c = 0; c < COLS; c++) act_in[c*BW_ACT +: BW_ACT] = BW_ACT'(beat_act[b][c]);
      for (int r = 0; r < ROWS; r++) wet_in[r*BW_WET +: BW_WET] = BW_WET'(beat_wet[b][r]);
      if (b == 0) begin
        cfg_k_len = K_W'(k);
        cfg_shift = 6'(sh);
        cfg_round = rnd;
        cfg_relu  = relu;
      end
      for (int t = 0; t < 300 && !in_ready; t++) begin
        @(posedge clk); #1;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic set_t1();
    for (int b = 0; b < 3; b++) begin
      beat_act[b][0] = 1; beat_act[b][1] = 2;
      beat_wet[b][0] = 3; beat_wet[b][1] = -1;
    end
  endtask

  task automatic run_uniform(input string name, input int a, input int w, input int sh,
                             input bit rnd, input bit relu, input logic [BW_OUT-1:0] ev);
    bit got;
    for (int c = 0; c < COLS; c++) beat_act[0][c] = a;
    for (int r = 0; r < ROWS; r++) beat_wet[0][r] = w;
    send_tile(1, sh, rnd, relu, 1'b0);
    wait_cycles_valid(got);
    if (got) check(name, 64'(out_data), 64'({NC{ev}}));
    wait_idle();
  endtask

  initial begin
    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // T1 with latency: POST follows the accepting edge, OUT the edge after.
    set_t1();
    send_tile(3, 0, 1'b0, 1'b0, 1'b0);
    check("t1_post_cycle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("t1_latency_valid", 64'(out_valid), 64'd1);
    check("t1_tile", 64'(out_data), 64'h0000_0000_FAFD_1209);
    wait_idle();

    run_uniform("t2_pos_sat", 127, 127, 0, 1'b0, 1'b0, 8'd127);
    run_uniform("t2_neg_sat", -128, 127, 0, 1'b0, 1'b0, 8'h80);
    run_uniform("t3_trunc", 5, 1, 1, 1'b0, 1'b0, 8'd2);
    run_uniform("t3_round", 5, 1, 1, 1'b1, 1'b0, 8'd3);
    run_uniform("t3_round_neg", -5, 1, 1, 1'b1, 1'b0, 8'hFE);
    run_uniform("t4_relu_on", -4, 2, 0, 1'b0, 1'b1, 8'd0);
    run_uniform("t4_relu_off", -4, 2, 0, 1'b0, 1'b0, 8'hF8);

    // T5 backpressure with junk beats offered while the tile is held.
    out_ready = 1'b0;
    for (int c = 0; c < COLS; c++) beat_act[0][c] = 3 + c;
    for (int r = 0; r < ROWS; r++) beat_wet[0][r] = -7 + r;
    send_tile(1, 0, 1'b0, 1'b0, 1'b0);
    wait_cycles_valid(ok);
    snap = out_data;
    for (int i = 0; i < 10; i++) begin
      junk_inputs();
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("t5_hold_valid", 64'(out_valid), 64'd1);
      check("t5_hold_data", 64'(out_data), 64'(snap));
      check("t5_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_release_valid", 64'(out_valid), 64'd0);
    check("t5_release_idle", 64'(busy), 64'd0);

    // T6: T1 data with random in_valid gaps.
    set_t1();
    send_tile(3, 0, 1'b0, 1'b0, 1'b1);
    wait_cycles_valid(ok);
    if (ok) check("t6_gapped_tile", 64'(out_data), 64'h0000_0000_FAFD_1209);
    wait_idle();

    // Reset mid-accumulation: asynchronous clear, no tile afterwards.
    junk_inputs();
    cfg_k_len = K_W'(5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    junk_inputs();
    @(posedge clk); #1;
    check("abort_busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #2;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end

    // Randomized tiles with random output backpressure.
    rand_ready_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int k, sh;
      k = $urandom_range(0, 6);
      sh = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 63) : $urandom_range(0, 10);
      for (int b = 0; b < 6; b++) begin
        for (int c = 0; c < COLS; c++) beat_act[b][c] = $urandom_range(0, 255) - 128;
        for (int r = 0; r < ROWS; r++) beat_wet[b][r] = $urandom_range(0, 255) - 128;
      end
      send_tile(k, sh, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_ready_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
